// File: rtl/vga_console_pkg.sv
// ---------------------------------------------------------------------------
// vga_console_pkg
// Shared constants and types for the text console that drives an 80x25
// character video RAM.
//   - Screen geometry (COLS, ROWS, SCREEN) and derived 12-bit address marks
//   - Control codes (backspace, line feed, form feed, carriage return, blank)
//   - FSM state encoding and the cursor operation encoding
//   - cellAddr(): row*80+col in 12-bit unsigned arithmetic
// No ports (package).
// ---------------------------------------------------------------------------
package vga_console_pkg;

   localparam int COLS   = 80;
   localparam int ROWS   = 25;
   localparam int SCREEN = 2000;

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_BLANK = 8'h20;

   localparam logic [6:0]  LAST_COL        = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW        = 5'(ROWS - 1);
   localparam logic [11:0] ROW_LEN         = 12'(COLS);
   localparam logic [11:0] SCREEN_LAST     = 12'(SCREEN - 1);
   localparam logic [11:0] LAST_ROW_BASE   = 12'(SCREEN - COLS);
   localparam logic [11:0] SCROLL_DST_LAST = 12'(SCREEN - COLS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      SCROLL_RD,
      SCROLL_WR,
      FILL,
      CLEAR
   } consoleState_e;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_STEP,
      OP_CR,
      OP_BS,
      OP_LF,
      OP_HOME
   } cursorOp_e;

   // row*80+col built from shifts so it stays 12-bit unsigned throughout
   function automatic logic [11:0] cellAddr(input logic [4:0] row, input logic [6:0] col);
      return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
   endfunction

endpackage

// File: rtl/vga_console_cursor.sv
// ---------------------------------------------------------------------------
// vga_console_cursor
// Cursor column/row counters for the console. Applies one operation per
// cycle: step right (wrapping into a row advance), carriage return,
// saturating backspace, line feed, or home.
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset (cursor to 0/0)
//   i_op       operation to apply this cycle (OP_NONE = hold)
//   i_wrapRow  1: advancing past the last row returns to row 0
//              0: advancing past the last row keeps the last row (scroll)
//   o_col      cursor column 0..79
//   o_row      cursor row 0..24
//   o_lastCol  cursor sits in column 79
//   o_lastRow  cursor sits in row 24
// ---------------------------------------------------------------------------
module vga_console_cursor
   import vga_console_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  cursorOp_e  i_op,
   input  logic       i_wrapRow,
   output logic [6:0] o_col,
   output logic [4:0] o_row,
   output logic       o_lastCol,
   output logic       o_lastRow
);

   logic [6:0] r_col;
   logic [4:0] r_row;
   logic [4:0] w_rowAdvanced;

   // Row after a line advance: the last row either wraps to the top or is
   // held, in which case the FSM is responsible for scrolling the text up.
   always_comb begin
      w_rowAdvanced = r_row + 5'd1;
      if (r_row == LAST_ROW) begin
         w_rowAdvanced = i_wrapRow ? 5'd0 : LAST_ROW;
      end
   end

   // Cursor update. A step past column 79 returns to column 0 and advances
   // the row exactly like a line feed; backspace never goes below column 0.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_col <= 7'd0;
         r_row <= 5'd0;
      end else begin
         case (i_op)
            OP_STEP: begin
               if (r_col == LAST_COL) begin
                  r_col <= 7'd0;
                  r_row <= w_rowAdvanced;
               end else begin
                  r_col <= r_col + 7'd1;
               end
            end
            OP_CR: r_col <= 7'd0;
            OP_BS: begin
               if (r_col != 7'd0) begin
                  r_col <= r_col - 7'd1;
               end
            end
            OP_LF: r_row <= w_rowAdvanced;
            OP_HOME: begin
               r_col <= 7'd0;
               r_row <= 5'd0;
            end
            default: begin
               r_col <= r_col;
            end
         endcase
      end
   end

   assign o_col     = r_col;
   assign o_row     = r_row;
   assign o_lastCol = (r_col == LAST_COL);
   assign o_lastRow = (r_row == LAST_ROW);

endmodule

// File: rtl/vga_console.sv
// ---------------------------------------------------------------------------
// vga_console
// Character console front end: accepts one character at a time and turns it
// into video RAM traffic (80x25 cells, address = row*80+col).
// Build option: define VGA_CONSOLE_SCROLL_EN to scroll the screen up one row
// when the cursor advances past row 24; without it the cursor wraps to row 0
// and the top row is blanked instead.
// Ports:
//   clk_cpu_i     system clock, rising edge
//   rst_i         synchronous active-high reset
//   char_valid_i  character offered
//   char_i        character code
//   char_ready_o  character can be accepted (IDLE only)
//   vga_en_o      video RAM access strobe
//   vga_we_o      video RAM write enable
//   vga_addr_o    video RAM address
//   vga_din_o     video RAM write data
//   vga_dout_i    video RAM read data, valid the cycle after a read strobe
//   col_o/row_o   cursor position
//   status_o      [0] display enabled, [1] cursor visible
// ---------------------------------------------------------------------------
module vga_console
   import vga_console_pkg::*;
(
   input  logic        clk_cpu_i,
   input  logic        rst_i,
   input  logic        char_valid_i,
   input  logic [7:0]  char_i,
   output logic        char_ready_o,
   output logic        vga_en_o,
   output logic        vga_we_o,
   output logic [11:0] vga_addr_o,
   output logic [7:0]  vga_din_o,
   input  logic [7:0]  vga_dout_i,
   output logic [6:0]  col_o,
   output logic [4:0]  row_o,
   output logic [1:0]  status_o
);

   consoleState_e r_state;
   cursorOp_e     r_op;
   logic          r_needClear;
   logic          r_ready;
   logic          r_en;
   logic          r_we;
   logic [11:0]   r_addr;
   logic [7:0]    r_din;
   logic          r_passDout;
   logic          r_dispEn;
   logic          r_cursorVis;

   logic [6:0]    w_col;
   logic [4:0]    w_row;
   logic          w_lastCol;
   logic          w_lastRow;
   logic          w_printable;
   logic          w_wrapRow;
   consoleState_e w_ovfState;
   logic [11:0]   w_ovfAddr;
   logic          w_ovfWe;
   logic [11:0]   w_fillLast;

   // What happens when the cursor runs off the bottom row: either start the
   // copy loop at source address 80, or go straight to blanking row 0.
`ifdef VGA_CONSOLE_SCROLL_EN
   assign w_wrapRow  = 1'b0;
   assign w_ovfState = SCROLL_RD;
   assign w_ovfAddr  = ROW_LEN;
   assign w_ovfWe    = 1'b0;
   assign w_fillLast = SCREEN_LAST;
`else
   assign w_wrapRow  = 1'b1;
   assign w_ovfState = FILL;
   assign w_ovfAddr  = 12'd0;
   assign w_ovfWe    = 1'b1;
   assign w_fillLast = ROW_LEN - 12'd1;
`endif

   assign w_printable = (char_i >= 8'h20) && (char_i <= 8'h7E);

   // The cursor applies r_op one cycle after the FSM latches it, so cursor
   // outputs change on the cycle following the transition that caused them
   // and the FSM still sees the old position while it decides what follows.
   vga_console_cursor u_cursor (
      .i_clk     (clk_cpu_i),
      .i_rst     (rst_i),
      .i_op      (r_op),
      .i_wrapRow (w_wrapRow),
      .o_col     (w_col),
      .o_row     (w_row),
      .o_lastCol (w_lastCol),
      .o_lastRow (w_lastRow)
   );

   // Main FSM. Every output register describes the access of the state being
   // entered, so the RAM strobe, address and data line up with r_state.
   // Reset parks in IDLE with r_needClear set; the first free cycle then
   // launches the full-screen clear before char_ready_o can rise.
   // WRITE is a single-cycle "apply" state for every non-clear character;
   // only printable codes carry a RAM write there.
   // The SCROLL_RD/SCROLL_WR arms are only ever entered through w_ovfState,
   // so without the scroll option they are unreachable.
   always_ff @(posedge clk_cpu_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_op        <= OP_NONE;
         r_needClear <= 1'b1;
         r_ready     <= 1'b0;
         r_en        <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= 12'd0;
         r_din       <= 8'd0;
         r_passDout  <= 1'b0;
         r_dispEn    <= 1'b0;
         r_cursorVis <= 1'b0;
      end else begin
         r_op       <= OP_NONE;
         r_passDout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_needClear) begin
                  r_needClear <= 1'b0;
                  r_state     <= CLEAR;
                  r_en        <= 1'b1;
                  r_we        <= 1'b1;
                  r_addr      <= 12'd0;
                  r_din       <= CH_BLANK;
               end else if (char_valid_i && r_ready) begin
                  r_ready     <= 1'b0;
                  r_cursorVis <= 1'b0;
                  if (char_i == CH_FF) begin
                     r_state <= CLEAR;
                     r_op    <= OP_HOME;
                     r_en    <= 1'b1;
                     r_we    <= 1'b1;
                     r_addr  <= 12'd0;
                     r_din   <= CH_BLANK;
                  end else if ((char_i == CH_LF) && w_lastRow) begin
                     r_state <= w_ovfState;
                     r_op    <= OP_LF;
                     r_en    <= 1'b1;
                     r_we    <= w_ovfWe;
                     r_addr  <= w_ovfAddr;
                     r_din   <= CH_BLANK;
                  end else begin
                     r_state <= WRITE;
                     if (w_printable) begin
                        r_op   <= OP_STEP;
                        r_en   <= 1'b1;
                        r_we   <= 1'b1;
                        r_addr <= cellAddr(w_row, w_col);
                        r_din  <= char_i;
                     end else begin
                        r_en <= 1'b0;
                        r_we <= 1'b0;
                        case (char_i)
                           CH_CR:   r_op <= OP_CR;
                           CH_BS:   r_op <= OP_BS;
                           CH_LF:   r_op <= OP_LF;
                           default: r_op <= OP_NONE;
                        endcase
                     end
                  end
               end
            end
            WRITE: begin
               if ((r_op == OP_STEP) && w_lastCol && w_lastRow) begin
                  r_state <= w_ovfState;
                  r_en    <= 1'b1;
                  r_we    <= w_ovfWe;
                  r_addr  <= w_ovfAddr;
                  r_din   <= CH_BLANK;
               end else begin
                  r_state     <= IDLE;
                  r_en        <= 1'b0;
                  r_we        <= 1'b0;
                  r_ready     <= 1'b1;
                  r_cursorVis <= 1'b1;
               end
            end
            SCROLL_RD: begin
               r_state    <= SCROLL_WR;
               r_we       <= 1'b1;
               r_addr     <= r_addr - ROW_LEN;
               r_passDout <= 1'b1;
            end
            SCROLL_WR: begin
               if (r_addr == SCROLL_DST_LAST) begin
                  r_state <= FILL;
                  r_we    <= 1'b1;
                  r_addr  <= LAST_ROW_BASE;
                  r_din   <= CH_BLANK;
               end else begin
                  r_state <= SCROLL_RD;
                  r_we    <= 1'b0;
                  r_addr  <= r_addr + ROW_LEN + 12'd1;
               end
            end
            FILL: begin
               if (r_addr == w_fillLast) begin
                  r_state     <= IDLE;
                  r_en        <= 1'b0;
                  r_we        <= 1'b0;
                  r_ready     <= 1'b1;
                  r_cursorVis <= 1'b1;
               end else begin
                  r_addr <= r_addr + 12'd1;
               end
            end
            CLEAR: begin
               if (r_addr == SCREEN_LAST) begin
                  r_state     <= IDLE;
                  r_en        <= 1'b0;
                  r_we        <= 1'b0;
                  r_ready     <= 1'b1;
                  r_cursorVis <= 1'b1;
                  r_dispEn    <= 1'b1;
               end else begin
                  r_addr <= r_addr + 12'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_en    <= 1'b0;
               r_we    <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Read data only arrives in the SCROLL_WR cycle itself, so the write data
   // is steered straight from the RAM output by a registered select.
   assign vga_din_o    = r_passDout ? vga_dout_i : r_din;
   assign char_ready_o = r_ready;
   assign vga_en_o     = r_en;
   assign vga_we_o     = r_we;
   assign vga_addr_o   = r_addr;
   assign col_o        = w_col;
   assign row_o        = w_row;
   assign status_o     = {r_cursorVis, r_dispEn};

endmodule

// File: doc/vga_console.md
VGA_CONSOLE -- requirements
Module: vga_console

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no other clock domains.
REQ-002 SHALL have the following ports (name  direction  width  meaning):
- clk_cpu_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- char_valid_i  in  1  character offered.
- char_i  in  8  character code.
- char_ready_o  out  1  block can accept a character.
- vga_en_o  out  1  video RAM access strobe.
- vga_we_o  out  1  video RAM write enable.
- vga_addr_o  out  12  video RAM address, row*80+col.
- vga_din_o  out  8  video RAM write data.
- vga_dout_i  in  8  video RAM read data, valid 1 cycle after a read strobe.
- col_o  out  7  cursor column, 0..79.
- row_o  out  5  cursor row, 0..24.
- status_o  out  2  [0] display enable, [1] cursor visible.

Function
REQ-003 SHALL transfer a character on a cycle where char_valid_i and char_ready_o are both high.
REQ-004 SHALL assert char_ready_o only in IDLE; it SHALL be low from the cycle after acceptance until the block returns to IDLE.
REQ-005 SHALL implement the states IDLE, WRITE, SCROLL_RD, SCROLL_WR, FILL and CLEAR.
REQ-006 Printable characters 0x20..0x7E:
- IDLE->WRITE; one write of char_i to the cursor address; col+1.
- At col 79: col=0 and row advances (REQ-009).
- Back to IDLE the next cycle.
REQ-007 Control characters:
- 0x0D: col=0.
- 0x08: col-1, saturating at 0; no RAM write.
- 0x0A: row advances (REQ-009); col unchanged.
- 0x0C: enter CLEAR.
- Any other code: consumed with no effect; back in IDLE in 1 cycle.
REQ-008 CLEAR SHALL:
- write 0x20 to addresses 0..1999 at one write per cycle (2000 cycles);
- set col=0, row=0;
- return to IDLE.
REQ-009 Row advance:
- row<24: row+1.
- row=24: enter SCROLL_RD; row stays 24.
REQ-010 Scroll SHALL:
- copy addresses 80..1999 to 0..1919 by alternating SCROLL_RD (read strobe at src) and SCROLL_WR (write vga_dout_i to src-80), 2 cycles per character;
- then FILL writes 0x20 to 1920..1999;
- then return to IDLE.
REQ-011 vga_en_o SHALL be high only on cycles that carry a RAM access; vga_we_o SHALL be low whenever vga_en_o is low.
REQ-012 Address arithmetic SHALL be 12-bit unsigned; the maximum address issued SHALL be 1999.
REQ-013 status_o:
- [0] high except during the post-reset CLEAR;
- [1] high only in IDLE.
REQ-014 col_o/row_o SHALL be registered and SHALL update on the cycle after the state transition that changes them.

Reset
REQ-015 rst_i SHALL take effect on the next clock edge, including mid-WRITE, mid-scroll and mid-CLEAR, abandoning the operation in progress.
REQ-016 Reset values SHALL be:
- char_ready_o=0, vga_en_o=0, vga_we_o=0;
- vga_addr_o=0, vga_din_o=0;
- col_o=0, row_o=0;
- status_o=2'b00.
REQ-017 After reset release the block SHALL run CLEAR (REQ-008) before first asserting char_ready_o.

Configuration
REQ-018 With VGA_CONSOLE_SCROLL_EN defined, row advance at row 24 SHALL scroll as in REQ-010.
REQ-019 Without VGA_CONSOLE_SCROLL_EN, row advance at row 24 SHALL:
- set row=0;
- FILL addresses 0..79 with 0x20;
- omit SCROLL_RD/SCROLL_WR entirely.

Structure
REQ-020 Package vga_console_pkg SHALL hold:
- COLS=80, ROWS=25, SCREEN=2000;
- control codes 0x08, 0x0A, 0x0C, 0x0D, blank 0x20;
- the state encoding.
REQ-021 Cursor column/row counting with wrap and saturation SHALL live in sub-module vga_console_cursor; the FSM and RAM sequencing SHALL stay in vga_console.

Verification
REQ-022 Release reset -> exactly 2000 writes of 0x20 to 0..1999, then char_ready_o=1, col/row=0/0, status_o=2'b11.
REQ-023 Send "A" (0x41) at 0/0 -> one write addr 0, data 0x41; col_o=1; char_ready_o low 1 cycle.
REQ-024 Cursor 79/3, send 0x42 -> write addr 319; col_o=0, row_o=4.
REQ-025 Row 24, send 0x0A (SCROLL_EN defined) -> data previously at 80+k lands at k for k=0..1919; 1920..1999 = 0x20; row_o=24; ready after 3920 busy cycles.
REQ-026 Same stimulus without SCROLL_EN -> row_o=0, 0..79 = 0x20, rows 1..24 untouched.
REQ-027 Assert rst_i at the 100th cycle of a scroll -> next cycle all outputs at reset values; full CLEAR follows.
